// File: rtl/axi4l_pkg.sv
// Shared types for the AXI4-Lite register slave: response codes, FSM states,
// and the byte-lane merge used when write strobes are honoured.
package axi4l_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_WAIT_W  = 2'd1,
    WR_WAIT_AW = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = new_v[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers (RW drive reg_o, RO read status_i).
// Define AXI4L_WSTRB_EN to honour wstrb per byte lane; otherwise writes are full-word.
module axi4l_reg_slave
  import axi4l_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDR_WIDTH-1:0]    araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [NUM_REGS*32-1:0]   reg_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o,
  input  logic [NUM_REGS*32-1:0]   status_i,
  output wr_state_t                wr_state_o,
  output rd_state_t                rd_state_o
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both high; valid, once raised, holds its payload stable
  // until that edge, and ready never depends combinationally on valid.

  localparam int IDXW = ADDR_WIDTH - 2;

  if (DATA_WIDTH != 32) begin : g_dw_check
    $error("axi4l_reg_slave: DATA_WIDTH must be 32");
  end

  wr_state_t                   wr_state_q, wr_state_d;
  rd_state_t                   rd_state_q, rd_state_d;
  logic [NUM_REGS-1:0][31:0]   regs_q, regs_d;
  logic [NUM_REGS-1:0]         pulse_q, pulse_d;
  logic [ADDR_WIDTH-1:0]       aw_addr_q, aw_addr_d;
  logic [31:0]                 w_data_q, w_data_d;
  logic [3:0]                  w_strb_q, w_strb_d;
  resp_t                       bresp_q, bresp_d;
  logic [31:0]                 rdata_q, rdata_d;
  resp_t                       rresp_q, rresp_d;

  logic                        commit;
  logic [ADDR_WIDTH-1:0]       c_addr;
  logic [31:0]                 c_data;
  logic [3:0]                  c_strb;
  logic [IDXW-1:0]             wr_idx, rd_idx;
  logic                        wr_hit, rd_hit;
  logic                        unused_bits;

  assign unused_bits = ^{awaddr[1:0], araddr[1:0], aw_addr_q[1:0], c_addr[1:0], c_strb};

  // Write FSM: accept AW and W in either order, commit once both halves are held.
  always_comb begin
    wr_state_d = wr_state_q;
    awready    = 1'b0;
    wready     = 1'b0;
    commit     = 1'b0;
    c_addr     = awaddr;
    c_data     = wdata;
    c_strb     = wstrb;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    case (wr_state_q)
      WR_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (awvalid && wvalid) begin
          commit     = 1'b1;
          wr_state_d = WR_RESP;
        end else if (awvalid) begin
          aw_addr_d  = awaddr;
          wr_state_d = WR_WAIT_W;
        end else if (wvalid) begin
          w_data_d   = wdata;
          w_strb_d   = wstrb;
          wr_state_d = WR_WAIT_AW;
        end
      end
      WR_WAIT_W: begin
        wready = 1'b1;
        c_addr = aw_addr_q;
        if (wvalid) begin
          commit     = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_WAIT_AW: begin
        awready = 1'b1;
        c_data  = w_data_q;
        c_strb  = w_strb_q;
        if (awvalid) begin
          commit     = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
    if (rst) begin
      awready = 1'b0;
      wready  = 1'b0;
    end
  end

  assign wr_idx = c_addr[ADDR_WIDTH-1:2];
  assign wr_hit = (wr_idx < IDXW'(NUM_REGS));

  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    bresp_d = bresp_q;
    if (commit) begin
      bresp_d = wr_hit ? OKAY : SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit && (wr_idx == IDXW'(i)) && !RO_MASK[i]) begin
          pulse_d[i] = 1'b1;
`ifdef AXI4L_WSTRB_EN
          regs_d[i]  = strb_merge(regs_q[i], c_data, c_strb);
`else
          regs_d[i]  = c_data;
`endif
        end
      end
    end
  end

  // Read FSM: data is captured at the AR handshake, so a same-cycle write commit
  // to the same register is not yet visible.
  assign rd_idx = araddr[ADDR_WIDTH-1:2];
  assign rd_hit = (rd_idx < IDXW'(NUM_REGS));

  always_comb begin
    rd_state_d = rd_state_q;
    arready    = 1'b0;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        arready = !rst;
        if (arvalid) begin
          rd_state_d = RD_DATA;
          rdata_d    = '0;
          rresp_d    = rd_hit ? OKAY : SLVERR;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_hit && (rd_idx == IDXW'(i))) begin
              rdata_d = RO_MASK[i] ? status_i[32*i +: 32] : regs_q[i];
            end
          end
        end
      end
      RD_DATA: begin
        if (rready) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      regs_q     <= '0;
      pulse_q    <= '0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= OKAY;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      regs_q     <= regs_d;
      pulse_q    <= pulse_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign bvalid     = (wr_state_q == WR_RESP);
  assign bresp      = bresp_q;
  assign rvalid     = (rd_state_q == RD_DATA);
  assign rdata      = rdata_q;
  assign rresp      = rresp_q;
  assign reg_o      = regs_q;
  assign wr_pulse_o = pulse_q;
  assign wr_state_o = wr_state_q;
  assign rd_state_o = rd_state_q;

endmodule
